// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// Optional checksum beat is enabled by defining REGFILE_DUMP_CHECKSUM_EN.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , ST_CSUM = 2'd3
`endif
    } dump_state_t;

    function automatic int unsigned words_of(input int unsigned bank_width);
        return 32'd1 << bank_width;
    endfunction

    // Beats per dump: one per register, plus the trailing checksum beat when enabled.
    function automatic int unsigned beat_count(input int unsigned bank_width);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        return words_of(bank_width) + 32'd1;
`else
        return words_of(bank_width);
`endif
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// Walks every register through the debug read port and streams one beat per register.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int BANK_WIDTH = 5,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [BANK_WIDTH-1:0] ra_db,
    input  logic [WIDTH-1:0]      rd_db,
    output logic [WIDTH-1:0]      out_data,
    output logic [BANK_WIDTH-1:0] out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output dump_state_t           dbg_state
);

    localparam logic [BANK_WIDTH-1:0] LAST_IDX = BANK_WIDTH'(words_of(BANK_WIDTH) - 1);

    dump_state_t           r_state;
    logic [BANK_WIDTH-1:0] r_idx;
    logic [WIDTH-1:0]      r_out_data;
    logic [BANK_WIDTH-1:0] r_out_idx;
    logic                  r_done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0]      r_csum;
`endif

    // Handshake: a beat transfers on a rising edge where out_valid and out_ready
    // are both high; out_data/out_idx/out_last stay frozen while out_valid waits.
    assign ra_db     = r_idx;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            ST_SEND: begin
                out_valid = 1'b1;
`ifndef REGFILE_DUMP_CHECKSUM_EN
                out_last  = (r_idx == LAST_IDX);
`endif
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_done     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // rd_db is combinational from ra_db, so this edge snapshots r_idx's register.
                    r_out_data <= rd_db;
                    r_out_idx  <= r_idx;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    r_csum     <= r_csum ^ rd_db;
`endif
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            r_out_data <= r_csum;
                            r_out_idx  <= '0;
                            r_state    <= ST_CSUM;
`else
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
`endif
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (out_ready) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default 5, register address width; number of words WORDS = 2**BANK_WIDTH.
REQ-002 SHALL have parameter WIDTH, default 64, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port ra_db  output  BANK_WIDTH  debug read address driven to the register file.
REQ-007 SHALL have port rd_db  input  WIDTH  asynchronous debug read data returned for ra_db in the same cycle.
REQ-008 SHALL have port out_data  output  WIDTH  captured register value (or checksum beat).
REQ-009 SHALL have port out_idx  output  BANK_WIDTH  register index of the current beat.
REQ-010 SHALL have port out_valid  output  1  beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_last  output  1  final beat of the dump.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SEND and, with the macro, CSUM.
REQ-016 IDLE: start=1 SHALL clear idx to 0 and go to LOAD; start in any other state SHALL be ignored.
REQ-017 LOAD: ra_db SHALL equal idx; on the clock edge, rd_db SHALL be captured into out_data, idx into out_idx, and the state SHALL go to SEND.
REQ-018 SEND: out_valid SHALL be 1, and out_data/out_idx SHALL be held stable until out_valid&out_ready.
REQ-019 On acceptance with idx<WORDS-1, idx SHALL increment and the state SHALL return to LOAD; minimum 2 cycles per beat.
REQ-020 On acceptance with idx=WORDS-1, the state SHALL go to CSUM (macro on) or IDLE with done=1 for one cycle (macro off).
REQ-021 Latency: start sampled at edge k SHALL give out_valid=1 in the cycle after edge k+1.
REQ-022 ra_db SHALL equal idx in all states; idx SHALL never wrap past WORDS-1.
REQ-023 out_last SHALL be 1 only on the final beat: idx=WORDS-1 in SEND (macro off), or in CSUM (macro on).
REQ-024 Each value SHALL be the register contents in its LOAD cycle; writes after capture SHALL NOT alter a held beat.

Reset
REQ-025 reset SHALL force IDLE from any state, including mid-dump, with no further beats emitted.
REQ-026 reset SHALL set idx=0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0, done=0, and checksum accumulator=0.

Configuration
REQ-027 Macro REGFILE_DUMP_CHECKSUM_EN defined SHALL add the CSUM state, with a WIDTH-bit XOR accumulator updated on each LOAD capture.
REQ-028 CSUM beat SHALL present out_data=accumulator, out_idx=0, out_valid=1, out_last=1; on acceptance the block SHALL pulse done and return to IDLE.
REQ-029 Macro undefined SHALL exclude the accumulator and CSUM state; the dump SHALL be exactly WORDS beats.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (dump_state_t) and the beat-count constant derivation.
REQ-031 The block SHALL be a single module; the XOR accumulator SHALL NOT be a sub-module.

Verification
REQ-032 Scenario: regs x1..x31 = 0x100+i, start pulse, out_ready=1 -> 32 beats, idx 0..31, data 0 then 0x101..0x11F, out_last on idx 31, done 1 cycle after, 64 cycles total.
REQ-033 Scenario: out_ready held 0 for 5 cycles at idx 3 -> out_valid stays 1, out_data=0x103 and out_idx=3 stable, no skip or duplicate.
REQ-034 Scenario: start re-pulsed at idx 10 -> ignored, dump completes with exactly 32 beats.
REQ-035 Scenario: reset asserted at idx 7 in SEND -> next cycle out_valid=0, busy=0, ra_db=0; new start restarts from idx 0.
REQ-036 Scenario (macro on): x1..x31 = 1<<(i-1) -> 33rd beat out_data=0x7FFFFFFF, out_idx=0, out_last=1.
REQ-037 Scenario: write x5=0xDEAD after its capture and before acceptance -> beat 5 still carries the old value.
